// File: rtl/fwd_bypass_unit.sv
// fwd_bypass_unit: EX-stage operand forwarding with a DEPTH-entry producer
// tag pipeline and load-use hazard detection.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), async active-low reset
//   adv_i               pipeline advance; tag pipeline shifts
//   bubble_i            with adv_i, shift an invalid entry into entry 0
//   flush_i             invalidate entry 0 (flush wins over consumer tag)
//   cons_we_i/rd_i/load_i  consumer tag captured into entry 0 on advance
//   src_ra_i            per-operand source register addresses
//   rf_data_i           per-operand register-file read data
//   stage_data_i        per-stage result data, slice k = entry k
//   src_data_o          forwarded operand data (combinational)
//   sel_o               0 = register file, k+1 = entry k (combinational)
//   hazard_o            load-use hazard on entry 0 (combinational)
//   fwd_cnt_o           per-operand saturating forward counters
//                       (only when FWD_STATS_EN is defined)
//
// Optional feature macro: FWD_STATS_EN
module fwd_bypass_unit #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RA_W    = 5,
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned NUM_SRC = 2,
    localparam int unsigned SEL_W  = $clog2(DEPTH + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      adv_i,
    input  logic                      bubble_i,
    input  logic                      flush_i,
    input  logic                      cons_we_i,
    input  logic [RA_W-1:0]           cons_rd_i,
    input  logic                      cons_load_i,
    input  logic [NUM_SRC*RA_W-1:0]   src_ra_i,
    input  logic [NUM_SRC*DATA_W-1:0] rf_data_i,
    input  logic [DEPTH*DATA_W-1:0]   stage_data_i,
    output logic [NUM_SRC*DATA_W-1:0] src_data_o,
    output logic [NUM_SRC*SEL_W-1:0]  sel_o,
    output logic                      hazard_o
`ifdef FWD_STATS_EN
    ,
    output logic [NUM_SRC*16-1:0]     fwd_cnt_o
`endif
);

    localparam int unsigned CNT_W = 16;

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] load_q;
    logic [RA_W-1:0]  rd_q [DEPTH];

    // Producer tag pipeline; flush only ever squashes the newest entry.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_q  <= '0;
            load_q <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                rd_q[k] <= '0;
            end
        end else if (adv_i) begin
            for (int k = 1; k < int'(DEPTH); k++) begin
                vld_q[k]  <= vld_q[k-1];
                load_q[k] <= load_q[k-1];
                rd_q[k]   <= rd_q[k-1];
            end
            vld_q[0]  <= cons_we_i & ~bubble_i & ~flush_i;
            load_q[0] <= cons_load_i;
            rd_q[0]   <= cons_rd_i;
        end else if (flush_i) begin
            vld_q[0] <= 1'b0;
        end
    end

    // Youngest match wins: scan oldest to youngest so entry 0 is assigned last.
    always_comb begin
        sel_o      = '0;
        src_data_o = rf_data_i;
        hazard_o   = 1'b0;
        for (int n = 0; n < int'(NUM_SRC); n++) begin
            for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
                if (vld_q[k] && (rd_q[k] == src_ra_i[n*RA_W +: RA_W]) &&
                    (src_ra_i[n*RA_W +: RA_W] != '0)) begin
                    sel_o[n*SEL_W +: SEL_W]       = SEL_W'(k + 1);
                    src_data_o[n*DATA_W +: DATA_W] = stage_data_i[k*DATA_W +: DATA_W];
                    // Entry 0 is the last iteration, so a hit here is the winner.
                    if (k == 0) begin
                        hazard_o = hazard_o | load_q[0];
                    end
                end
            end
        end
    end

`ifdef FWD_STATS_EN
    // Per-operand forward counters; a flushing advance clears them.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fwd_cnt_o <= '0;
        end else if (adv_i && flush_i) begin
            fwd_cnt_o <= '0;
        end else if (adv_i && !hazard_o) begin
            for (int n = 0; n < int'(NUM_SRC); n++) begin
                if ((sel_o[n*SEL_W +: SEL_W] != '0) &&
                    (fwd_cnt_o[n*CNT_W +: CNT_W] != 16'hFFFF)) begin
                    fwd_cnt_o[n*CNT_W +: CNT_W] <= fwd_cnt_o[n*CNT_W +: CNT_W] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_bypass_unit.sv
// Scoreboard bench for fwd_bypass_unit: directed vectors push expected
// sel/data/hazard; a negedge monitor pops and compares.
module tb_fwd_bypass_unit;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RA_W    = 5;
    localparam int unsigned DEPTH   = 3;
    localparam int unsigned NUM_SRC = 2;
    localparam int unsigned SEL_W   = 2;

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic                      adv_i;
    logic                      bubble_i;
    logic                      flush_i;
    logic                      cons_we_i;
    logic [RA_W-1:0]           cons_rd_i;
    logic                      cons_load_i;
    logic [NUM_SRC*RA_W-1:0]   src_ra_i;
    logic [NUM_SRC*DATA_W-1:0] rf_data_i;
    logic [DEPTH*DATA_W-1:0]   stage_data_i;
    logic [NUM_SRC*DATA_W-1:0] src_data_o;
    logic [NUM_SRC*SEL_W-1:0]  sel_o;
    logic                      hazard_o;
`ifdef FWD_STATS_EN
    logic [NUM_SRC*16-1:0]     fwd_cnt_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [NUM_SRC*SEL_W-1:0]  exp_sel_q  [$];
    logic [NUM_SRC*DATA_W-1:0] exp_data_q [$];
    logic                      exp_haz_q  [$];
    string                     exp_name_q [$];

    fwd_bypass_unit #(
        .DATA_W (DATA_W),
        .RA_W   (RA_W),
        .DEPTH  (DEPTH),
        .NUM_SRC(NUM_SRC)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .adv_i       (adv_i),
        .bubble_i    (bubble_i),
        .flush_i     (flush_i),
        .cons_we_i   (cons_we_i),
        .cons_rd_i   (cons_rd_i),
        .cons_load_i (cons_load_i),
        .src_ra_i    (src_ra_i),
        .rf_data_i   (rf_data_i),
        .stage_data_i(stage_data_i),
        .src_data_o  (src_data_o),
        .sel_o       (sel_o),
        .hazard_o    (hazard_o)
`ifdef FWD_STATS_EN
        ,
        .fwd_cnt_o   (fwd_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Monitor: the DUT presents combinational results every cycle.
    always @(negedge clk_i) begin
        if (exp_sel_q.size() > 0) begin
            logic [NUM_SRC*SEL_W-1:0]  es;
            logic [NUM_SRC*DATA_W-1:0] ed;
            logic                      eh;
            string                     nm;
            es = exp_sel_q.pop_front();
            ed = exp_data_q.pop_front();
            eh = exp_haz_q.pop_front();
            nm = exp_name_q.pop_front();
            n_cmp++;
            if (sel_o !== es || src_data_o !== ed || hazard_o !== eh) begin
                n_bad++;
                $display("FAIL %s: got sel=%h data=%h haz=%b, want sel=%h data=%h haz=%b",
                         nm, sel_o, src_data_o, hazard_o, es, ed, eh);
            end
        end
    end

    // Drive one cycle of inputs and queue the expected combinational response.
    task automatic step(input logic rst, input logic adv, input logic bub,
                        input logic fl, input logic we, input logic [RA_W-1:0] rd,
                        input logic ld, input logic [RA_W-1:0] ra0,
                        input logic [RA_W-1:0] ra1, input int s0, input int s1,
                        input logic eh, input string nm);
        logic [NUM_SRC*SEL_W-1:0]  es;
        logic [NUM_SRC*DATA_W-1:0] ed;
        int                        sv [2];
        rst_i       = rst;
        adv_i       = adv;
        bubble_i    = bub;
        flush_i     = fl;
        cons_we_i   = we;
        cons_rd_i   = rd;
        cons_load_i = ld;
        src_ra_i    = {ra1, ra0};
        sv[0] = s0;
        sv[1] = s1;
        for (int n = 0; n < 2; n++) begin
            es[n*SEL_W +: SEL_W] = SEL_W'(sv[n]);
            if (sv[n] == 0) ed[n*DATA_W +: DATA_W] = rf_data_i[n*DATA_W +: DATA_W];
            else            ed[n*DATA_W +: DATA_W] = stage_data_i[(sv[n]-1)*DATA_W +: DATA_W];
        end
        exp_sel_q.push_back(es);
        exp_data_q.push_back(ed);
        exp_haz_q.push_back(eh);
        exp_name_q.push_back(nm);
        @(posedge clk_i);
        #1;
    endtask

`ifdef FWD_STATS_EN
    task automatic check_cnt(input string nm, input logic [NUM_SRC*16-1:0] exp);
        n_cmp++;
        if (fwd_cnt_o !== exp) begin
            n_bad++;
            $display("FAIL %s: got fwd_cnt=%h, want %h", nm, fwd_cnt_o, exp);
        end
    endtask
`endif

    initial begin
        rst_i        = 1'b0;
        adv_i        = 1'b0;
        bubble_i     = 1'b0;
        flush_i      = 1'b0;
        cons_we_i    = 1'b0;
        cons_rd_i    = '0;
        cons_load_i  = 1'b0;
        src_ra_i     = '0;
        rf_data_i    = {32'h22222222, 32'h11111111};
        stage_data_i = {32'h0000000C, 32'h0000000B, 32'hDEADBEEF};
        @(posedge clk_i);
        #1;
        //   rst adv bub fl we rd ld ra0 ra1 s0 s1 hz
        step(0, 1, 0, 0, 1, 5, 0, 5, 6, 0, 0, 0, "reset");
        step(1, 0, 0, 0, 1, 5, 0, 5, 6, 0, 0, 0, "rst_release_hold");
        step(1, 1, 0, 0, 1, 5, 0, 5, 6, 0, 0, 0, "adv_issue");
        step(1, 0, 0, 0, 0, 0, 0, 5, 6, 1, 0, 0, "ex_ex");
        step(1, 1, 0, 0, 1, 7, 0, 5, 6, 1, 0, 0, "ex_ex_adv");
        stage_data_i = {32'h0000000C, 32'h0000000B, 32'h0000000A};
        step(1, 1, 0, 0, 1, 7, 0, 7, 5, 1, 2, 0, "second_rd7");
        step(1, 0, 0, 0, 0, 0, 0, 7, 5, 1, 3, 0, "priority");
        step(1, 1, 1, 0, 1, 7, 0, 7, 0, 1, 0, 0, "bubble1");
        step(1, 1, 1, 0, 0, 0, 0, 7, 0, 2, 0, 0, "bubble2");
        step(1, 0, 0, 0, 0, 0, 0, 7, 0, 3, 0, 0, "age_out_3");
        step(1, 1, 1, 0, 0, 0, 0, 7, 0, 3, 0, 0, "last_adv");
        step(1, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, "aged_out");
        step(1, 1, 0, 0, 1, 9, 1, 0, 9, 0, 0, 0, "load_issue");
        step(1, 0, 1, 0, 0, 0, 0, 0, 9, 0, 1, 1, "load_use");
        step(1, 1, 1, 0, 0, 0, 0, 0, 9, 0, 1, 1, "hold_bubble_ignored");
        step(1, 0, 0, 0, 0, 0, 0, 0, 9, 0, 2, 0, "load_fwd");
        step(1, 1, 0, 0, 1, 0, 0, 0, 9, 0, 2, 0, "x0_issue");
        step(1, 0, 0, 0, 0, 0, 0, 0, 9, 0, 3, 0, "x0_no_fwd");
        step(1, 1, 0, 0, 1, 4, 0, 4, 0, 0, 0, 0, "rd4_issue");
        step(1, 0, 0, 1, 0, 0, 0, 4, 0, 1, 0, 0, "pre_flush");
        step(1, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, "flush_hold");
        step(1, 1, 0, 1, 1, 4, 0, 0, 0, 0, 0, 0, "flush_adv_issue");
        step(1, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, "flush_adv");
        step(1, 1, 0, 0, 1, 3, 0, 3, 0, 0, 0, 0, "rd3_issue");
        step(1, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, "pre_rst");
        step(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, "mid_rst");
        step(1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, "post_rst");
        step(1, 1, 0, 0, 1, 5, 0, 5, 0, 0, 0, 0, "cnt_issue");
        step(1, 1, 0, 0, 1, 5, 0, 5, 0, 1, 0, 0, "cnt_fwd1");
        step(1, 1, 0, 0, 1, 5, 0, 5, 0, 1, 0, 0, "cnt_fwd2");
        step(1, 1, 0, 0, 1, 5, 0, 5, 0, 1, 0, 0, "cnt_fwd3");
`ifdef FWD_STATS_EN
        check_cnt("fwd_cnt_3", {16'h0000, 16'h0003});
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk_i);
        end
        #1;
        check_cnt("fwd_cnt_sat", {16'h0000, 16'hFFFF});
        step(1, 1, 0, 1, 1, 5, 0, 5, 0, 1, 0, 0, "flush_adv_cnt");
        check_cnt("fwd_cnt_clear", {16'h0000, 16'h0000});
`endif
        @(negedge clk_i);
        #1;
        n_cmp++;
        if (exp_sel_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_sel_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
